// File: rtl/cnv_rd_sched_pkg.sv
// Shared types and defaults for the convolution read-side scheduler.
// The optional stall feature is enabled by defining CNV_RD_SCHED_HOLD_EN.
package cnv_rd_sched_pkg;

    localparam int DEPTHWIDTH_DEF = 9;
    localparam int KWIDTH_DEF     = 4;

    typedef logic [DEPTHWIDTH_DEF-1:0] loop_cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/cnv_rd_sched_if.sv
// Read-issue bus from the scheduler to the weight-update / MAC / kernel-accumulate stage.
// rd_dv qualifies the addresses and framing strobes for exactly one cycle; there is no
// ready/back-pressure on this bus, so the consumer must accept every strobed beat.
interface cnv_rd_sched_if #(
    parameter int DEPTHWIDTH = 9
);
    logic [DEPTHWIDTH-1:0] rd_wdepth;
    logic [DEPTHWIDTH-1:0] rd_fdepth;
    logic                  rd_dv;
    logic                  compute_en;
    logic                  kx_end;
    logic                  line_end;

    modport master (
        output rd_wdepth, rd_fdepth, rd_dv, compute_en, kx_end, line_end
    );

    modport slave (
        input rd_wdepth, rd_fdepth, rd_dv, compute_en, kx_end, line_end
    );
endinterface

// File: rtl/cnv_rd_sched_addr_gen.sv
// Nested co/kx/wo/ci loop counters with running base registers; addresses are base + ci,
// so the issue path needs only adders. Counters always describe the next position to issue.
module cnv_rd_addr_gen #(
    parameter int DEPTHWIDTH = 9,
    parameter int KWIDTH     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  adv_i,
    input  logic [DEPTHWIDTH-1:0] co_n_i,
    input  logic [DEPTHWIDTH-1:0] wo_n_i,
    input  logic [DEPTHWIDTH-1:0] ci_n_i,
    input  logic [KWIDTH-1:0]     kx_n_i,
    output logic [DEPTHWIDTH-1:0] wdepth_o,
    output logic [DEPTHWIDTH-1:0] fdepth_o,
    output logic                  kx_end_o,
    output logic                  line_end_o,
    output logic                  last_o
);
    localparam logic [DEPTHWIDTH-1:0] ONE_D = 1;
    localparam logic [KWIDTH-1:0]     ONE_K = 1;

    logic [DEPTHWIDTH-1:0] co_q, wo_q, ci_q;
    logic [KWIDTH-1:0]     kxi_q;
    logic [DEPTHWIDTH-1:0] wbase_q, fkx_q, fbase_q;
    logic                  ci_end, wo_end, kx_last, co_last;

    assign ci_end  = (ci_q == ci_n_i - ONE_D);
    assign wo_end  = (wo_q == wo_n_i - ONE_D);
    assign kx_last = (kxi_q == kx_n_i - ONE_K);
    assign co_last = (co_q == co_n_i - ONE_D);

    assign wdepth_o   = wbase_q + ci_q;
    assign fdepth_o   = fbase_q + ci_q;
    assign kx_end_o   = wo_end & ci_end;
    assign last_o     = kx_end_o & kx_last & co_last;
    assign line_end_o = last_o;

    // wbase tracks (co*kx + kx_i)*ci, fkx tracks kx_i*ci, fbase tracks (wo + kx_i)*ci.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clr_i) begin
            co_q    <= '0;
            wo_q    <= '0;
            ci_q    <= '0;
            kxi_q   <= '0;
            wbase_q <= '0;
            fkx_q   <= '0;
            fbase_q <= '0;
        end else if (adv_i) begin
            if (!ci_end) begin
                ci_q <= ci_q + ONE_D;
            end else begin
                ci_q <= '0;
                if (!wo_end) begin
                    wo_q    <= wo_q + ONE_D;
                    fbase_q <= fbase_q + ci_n_i;
                end else begin
                    wo_q    <= '0;
                    wbase_q <= wbase_q + ci_n_i;
                    if (!kx_last) begin
                        kxi_q   <= kxi_q + ONE_K;
                        fkx_q   <= fkx_q + ci_n_i;
                        fbase_q <= fkx_q + ci_n_i;
                    end else begin
                        kxi_q   <= '0;
                        fkx_q   <= '0;
                        fbase_q <= '0;
                        co_q    <= co_q + ONE_D;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/cnv_rd_sched.sv
// Read-side scheduler for one convolution output line: FSM, drain timer and stall gating.
// Stall via I_hold is active only when CNV_RD_SCHED_HOLD_EN is defined.
module cnv_rd_sched
    import cnv_rd_sched_pkg::*;
#(
    parameter int DEPTHWIDTH = DEPTHWIDTH_DEF,
    parameter int KWIDTH     = KWIDTH_DEF,
    parameter int DRAIN_LAT  = 4
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_start,
    input  logic                  I_hold,
    input  logic [DEPTHWIDTH-1:0] I_coGroup,
    input  logic [DEPTHWIDTH-1:0] I_ciGroup,
    input  logic [DEPTHWIDTH-1:0] I_woGroup,
    input  logic [KWIDTH-1:0]     I_kx,
    cnv_rd_sched_if.master        O_rd,
    output logic                  O_busy,
    output logic                  O_done,
    output sched_state_e          O_state
);
    sched_state_e          state_q;
    logic [3:0]            drain_q;
    logic [DEPTHWIDTH-1:0] co_cfg_q, ci_cfg_q, wo_cfg_q;
    logic [KWIDTH-1:0]     kx_cfg_q;
    logic [DEPTHWIDTH-1:0] wdepth_q, fdepth_q;
    logic                  dv_q, kx_end_q, line_end_q, busy_q, done_q;

    logic                  hold_eff, zero_cfg, issue, clr;
    logic [DEPTHWIDTH-1:0] co_n, ci_n, wo_n, a_wdepth, a_fdepth;
    logic [KWIDTH-1:0]     kx_n;
    logic                  a_kx_end, a_line_end, a_last;

`ifdef CNV_RD_SCHED_HOLD_EN
    assign hold_eff = I_hold;
`else
    assign hold_eff = I_hold & 1'b0;
`endif

    // While idle the generator sees the live inputs so the first issue leaves on the start edge.
    assign co_n = (state_q == IDLE) ? I_coGroup : co_cfg_q;
    assign ci_n = (state_q == IDLE) ? I_ciGroup : ci_cfg_q;
    assign wo_n = (state_q == IDLE) ? I_woGroup : wo_cfg_q;
    assign kx_n = (state_q == IDLE) ? I_kx      : kx_cfg_q;

    assign zero_cfg = (I_coGroup == '0) || (I_ciGroup == '0) ||
                      (I_woGroup == '0) || (I_kx == '0);
    assign issue = ((state_q == IDLE) && I_start && !zero_cfg) ||
                   ((state_q == RUN) && !hold_eff);
    assign clr   = !issue && (state_q != RUN);

    cnv_rd_addr_gen #(
        .DEPTHWIDTH(DEPTHWIDTH),
        .KWIDTH    (KWIDTH)
    ) u_addr_gen (
        .clk_i     (I_clk),
        .rst_i     (I_rst),
        .clr_i     (clr),
        .adv_i     (issue),
        .co_n_i    (co_n),
        .wo_n_i    (wo_n),
        .ci_n_i    (ci_n),
        .kx_n_i    (kx_n),
        .wdepth_o  (a_wdepth),
        .fdepth_o  (a_fdepth),
        .kx_end_o  (a_kx_end),
        .line_end_o(a_line_end),
        .last_o    (a_last)
    );

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q    <= IDLE;
            drain_q    <= '0;
            co_cfg_q   <= '0;
            ci_cfg_q   <= '0;
            wo_cfg_q   <= '0;
            kx_cfg_q   <= '0;
            wdepth_q   <= '0;
            fdepth_q   <= '0;
            dv_q       <= 1'b0;
            kx_end_q   <= 1'b0;
            line_end_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            dv_q       <= issue;
            kx_end_q   <= issue & a_kx_end;
            line_end_q <= issue & a_line_end;
            done_q     <= (state_q == DONE);
            if (issue) begin
                wdepth_q <= a_wdepth;
                fdepth_q <= a_fdepth;
            end
            // The state leaves RUN on the edge that launches the last issue.
            case (state_q)
                IDLE: begin
                    busy_q <= I_start;
                    if (I_start) begin
                        co_cfg_q <= I_coGroup;
                        ci_cfg_q <= I_ciGroup;
                        wo_cfg_q <= I_woGroup;
                        kx_cfg_q <= I_kx;
                        drain_q  <= '0;
                        if (zero_cfg)    state_q <= DONE;
                        else if (a_last) state_q <= DRAIN;
                        else             state_q <= RUN;
                    end
                end
                RUN: begin
                    busy_q <= 1'b1;
                    if (!hold_eff && a_last) begin
                        state_q <= DRAIN;
                        drain_q <= '0;
                    end
                end
                DRAIN: begin
                    busy_q <= 1'b1;
                    if (drain_q == 4'(DRAIN_LAT - 1)) state_q <= DONE;
                    else                             drain_q <= drain_q + 4'd1;
                end
                default: begin
                    busy_q  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign O_rd.rd_wdepth  = wdepth_q;
    assign O_rd.rd_fdepth  = fdepth_q;
    assign O_rd.rd_dv      = dv_q;
    assign O_rd.compute_en = dv_q;
    assign O_rd.kx_end     = kx_end_q;
    assign O_rd.line_end   = line_end_q;
    assign O_busy          = busy_q;
    assign O_done          = done_q;
    assign O_state         = state_q;
endmodule

// File: tb/tb_cnv_rd_sched.sv
// Directed bench for cnv_rd_sched: reset, line walks, zero counts, hold, reset mid-run,
// ignored restart and address wrap, checked against a nested-loop reference model.
module tb_cnv_rd_sched;
    import cnv_rd_sched_pkg::*;

    localparam int DW = 9;
    localparam int KW = 4;
    localparam int DL = 4;
`ifdef CNV_RD_SCHED_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, hold;
    loop_cnt_t     co_n, ci_n, wo_n;
    logic [KW-1:0] kx_n;
    logic          busy, done;
    sched_state_e  st;

    cnv_rd_sched_if #(.DEPTHWIDTH(DW)) rd_if ();

    cnv_rd_sched #(
        .DEPTHWIDTH(DW),
        .KWIDTH    (KW),
        .DRAIN_LAT (DL)
    ) dut (
        .I_clk    (clk),
        .I_rst    (rst),
        .I_start  (start),
        .I_hold   (hold),
        .I_coGroup(co_n),
        .I_ciGroup(ci_n),
        .I_woGroup(wo_n),
        .I_kx     (kx_n),
        .O_rd     (rd_if),
        .O_busy   (busy),
        .O_done   (done),
        .O_state  (st)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [20:0] exp_q[$];
    int obs_w[2048];
    int obs_f[2048];
    int obs_cyc[2048];
    int n_issue, n_kx, le_cyc, done_cyc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // driver + scoreboard for one line; restart_at/hold_after < 0 disable those events
    task automatic run_line(input int co, input int kx, input int wo, input int ci,
                            input int hold_after, input int hold_len, input int restart_at,
                            input string tag);
        int t, exp_done, budget, hold_left, busy_err, strobe_err, extra_done, extra_issue;
        bit hold_started;
        logic [20:0] pkt, e;
        exp_q.delete();
        t = 0;
        for (int c = 0; c < co; c++)
            for (int k = 0; k < kx; k++)
                for (int w = 0; w < wo; w++)
                    for (int i = 0; i < ci; i++) begin
                        e = {(c == co-1 && k == kx-1 && w == wo-1 && i == ci-1),
                             (w == wo-1 && i == ci-1), 1'b1,
                             9'(((c*kx + k)*ci + i) % 512), 9'(((w + k)*ci + i) % 512)};
                        exp_q.push_back(e);
                        t++;
                    end
        exp_done = (t == 0) ? 2 : t + DL + 1 + ((HOLD_EN && hold_after >= 0) ? hold_len : 0);
        budget = t + DL + hold_len + 40;
        n_issue = 0; n_kx = 0; le_cyc = -1; done_cyc = -1;
        hold_left = 0; hold_started = 0;
        busy_err = 0; strobe_err = 0; extra_done = 0; extra_issue = 0;
        co_n = loop_cnt_t'(co); kx_n = KW'(kx); wo_n = loop_cnt_t'(wo); ci_n = loop_cnt_t'(ci);
        start = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            step();
            start = (c == restart_at);
            if (done) begin
                if (done_cyc < 0) done_cyc = c;
                else extra_done++;
            end
            if (busy !== ((done_cyc < 0 || c == done_cyc) ? 1'b1 : 1'b0)) busy_err++;
            if (rd_if.rd_dv) begin
                pkt = {rd_if.line_end, rd_if.kx_end, rd_if.compute_en,
                       rd_if.rd_wdepth, rd_if.rd_fdepth};
                if (exp_q.size() == 0) extra_issue++;
                else begin
                    e = exp_q.pop_front();
                    chk($sformatf("%s_issue%0d", tag, n_issue), int'(pkt), int'(e));
                end
                if (n_issue < 2048) begin
                    obs_w[n_issue] = int'(rd_if.rd_wdepth);
                    obs_f[n_issue] = int'(rd_if.rd_fdepth);
                    obs_cyc[n_issue] = c;
                end
                n_issue++;
                if (rd_if.kx_end) n_kx++;
                if (rd_if.line_end) le_cyc = c;
            end else if (rd_if.compute_en || rd_if.kx_end || rd_if.line_end) begin
                strobe_err++;
            end
            if (n_issue == hold_after && !hold_started) begin
                hold_left = hold_len;
                hold_started = 1'b1;
            end
            hold = (hold_left > 0);
            if (hold_left > 0) hold_left--;
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        hold = 1'b0;
        start = 1'b0;
        chk({tag, "_done_cycle"}, done_cyc, exp_done);
        chk({tag, "_issue_count"}, n_issue, t);
        chk({tag, "_missing_issues"}, exp_q.size(), 0);
        chk({tag, "_extra_issues"}, extra_issue, 0);
        chk({tag, "_busy_window"}, busy_err, 0);
        chk({tag, "_idle_strobes"}, strobe_err, 0);
        chk({tag, "_done_pulses"}, extra_done, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dv"}, int'(rd_if.rd_dv), 0);
        chk({tag, "_wdepth"}, int'(rd_if.rd_wdepth), 0);
        chk({tag, "_fdepth"}, int'(rd_if.rd_fdepth), 0);
        chk({tag, "_compute_en"}, int'(rd_if.compute_en), 0);
        chk({tag, "_kx_end"}, int'(rd_if.kx_end), 0);
        chk({tag, "_line_end"}, int'(rd_if.line_end), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_state"}, int'(st), int'(IDLE));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        co_n = '0; ci_n = '0; wo_n = '0; kx_n = '0;
        step(); step(); step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // single short line: 4 issues, done after drain
        run_line(1, 1, 1, 4, -1, 0, -1, "t1");
        chk("t1_first_issue_cycle", obs_cyc[0], 1);
        chk("t1_last_issue_cycle", obs_cyc[3], 4);
        chk("t1_line_end_cycle", le_cyc, 4);

        // full nest: 24 issues, kx_end every 4th
        run_line(2, 3, 2, 2, -1, 0, -1, "t2");
        chk("t2_kx_end_count", n_kx, 6);
        chk("t2_wdepth_co1_kx0", obs_w[12], 6);
        chk("t2_fdepth_kx2_wo1_ci1", obs_f[11], 7);
        chk("t2_line_end_cycle", le_cyc, 24);

        // zero count: no issues, done two cycles after start
        run_line(1, 1, 1, 0, -1, 0, -1, "t_zero");
        run_line(0, 2, 2, 2, -1, 0, -1, "t_zero_co");

        // hold for 3 cycles after the 2nd issue
        run_line(1, 1, 1, 4, 2, 3, -1, "t_hold");
        chk("t_hold_addr2_cycle", obs_cyc[2], HOLD_EN ? 6 : 3);

        // reset in the middle of a run clears outputs without waiting for a clock
        co_n = 9'd1; kx_n = 4'd1; wo_n = 9'd1; ci_n = 9'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        step();
        rst = 1'b0;
        step();
        run_line(1, 1, 1, 8, -1, 0, -1, "t_after_reset");
        chk("t_after_reset_first_w", obs_w[0], 0);

        // start pulse during RUN is ignored
        run_line(1, 1, 1, 8, -1, 0, 3, "t_restart");

        // address wrap past 511
        run_line(1, 1, 64, 16, -1, 0, -1, "t_wrap_f");
        chk("t_wrap_f_511", obs_f[511], 511);
        chk("t_wrap_f_512", obs_f[512], 0);
        run_line(64, 1, 1, 16, -1, 0, -1, "t_wrap_w");
        chk("t_wrap_w_511", obs_w[511], 511);
        chk("t_wrap_w_512", obs_w[512], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
